// File: rtl/sram_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sram_bist : SRAM self-test sequencer in front of sram_driver (write, read,
//             compare; true then inverted pattern). Option: SRAM_BIST_TIMEOUT_EN
// Revision  : 1.0
// ============================================================================
module sram_bist #(
  parameter int                ADDR_W  = 13,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] SEED    = DATA_W'(8'hA5),
  parameter int                BLINK_W = 22
`ifdef SRAM_BIST_TIMEOUT_EN
  ,
  parameter int                TMO_W   = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              ready,
  output logic              start,
  output logic              re,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic              led
`ifdef SRAM_BIST_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                re_q, re_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                phase_q, phase_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                led_q, led_d;
  logic                mismatch;

`ifdef SRAM_BIST_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                timeout_q, timeout_d;
`endif

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic              ph);
    return (DATA_W'(a) ^ SEED) ^ {DATA_W{ph}};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      address_q   <= '0;
      data_in_q   <= '0;
      rdata_q     <= '0;
      re_q        <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      phase_q     <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
      blink_q     <= '0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      rdata_q     <= rdata_d;
      re_q        <= re_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      phase_q     <= phase_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
    end
  end

`ifdef SRAM_BIST_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    data_in_d   = data_in_q;
    rdata_d     = rdata_q;
    re_d        = re_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    phase_d     = phase_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    blink_d     = (done_q && !pass_q) ? blink_q + 1'b1 : '0;
`ifdef SRAM_BIST_TIMEOUT_EN
    tmo_d       = tmo_q;
    timeout_d   = timeout_q;
`endif
    mismatch    = (rdata_q != pattern(address_q, phase_q));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          err_addr_d  = '0;
          address_d   = '0;
          phase_d     = 1'b0;
          busy_d      = 1'b1;
`ifdef SRAM_BIST_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
          state_d     = S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (ready) begin
          start_d   = 1'b1;
          re_d      = 1'b0;
          data_in_d = pattern(address_q, phase_q);
`ifdef SRAM_BIST_TIMEOUT_EN
          tmo_d     = '0;
`endif
          state_d   = S_WR_WAIT;
        end
      end

      // While start_q is high the driver has not yet seen the request, so its
      // ready is stale and must be ignored for that one cycle.
      S_WR_WAIT: begin
        if (!start_q && ready) begin
          if (address_q == ADDR_MAX) begin
            address_d = '0;
            state_d   = S_RD_REQ;
          end else begin
            address_d = address_q + 1'b1;
            state_d   = S_WR_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (ready) begin
          start_d = 1'b1;
          re_d    = 1'b1;
`ifdef SRAM_BIST_TIMEOUT_EN
          tmo_d   = '0;
`endif
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (!start_q && ready) begin
          rdata_d = data_out;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          if (err_count_q == 8'd0)  err_addr_d  = address_q;
        end
        if (address_q != ADDR_MAX) begin
          address_d = address_q + 1'b1;
          state_d   = S_RD_REQ;
        end else if (!phase_q) begin
          phase_d   = 1'b1;
          address_d = '0;
          state_d   = S_WR_REQ;
        end else begin
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (err_count_d == 8'd0);
          state_d   = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef SRAM_BIST_TIMEOUT_EN
    // Count stalled cycles only after the request has been seen by the driver.
    if ((state_q == S_WR_WAIT || state_q == S_RD_WAIT) && !start_q && !ready) begin
      if (tmo_q == TMO_LAST) begin
        busy_d      = 1'b0;
        done_d      = 1'b1;
        pass_d      = 1'b0;
        err_count_d = 8'hFF;
        err_addr_d  = address_q;
        timeout_d   = 1'b1;
        state_d     = S_DONE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    led_d = done_d && (pass_d || blink_d[BLINK_W-1]);
  end

  assign start     = start_q;
  assign re        = re_q;
  assign address   = address_q;
  assign data_in   = data_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign led       = led_q;
`ifdef SRAM_BIST_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_bist.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for sram_bist: behavioural SRAM driver model, expected access sequence
// and error results derived from the pattern rule with plain loops.
module tb_sram_bist;
  localparam int AW  = 4;
  localparam int AW2 = 9;
  localparam int N   = 2 ** AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic ready, start, re, busy, done, pass, led;
  logic [AW-1:0] address, err_addr;
  logic [7:0]    data_in, data_out, err_count;
`ifdef SRAM_BIST_TIMEOUT_EN
  logic timeout, timeout2;
`endif

  logic run2 = 1'b0;
  logic ready2, start2, re2, busy2, done2, pass2, led2;
  logic [AW2-1:0] address2, err_addr2;
  logic [7:0]     data_in2, err_count2;
  logic [7:0]     zero_data = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_bist #(.ADDR_W(AW), .DATA_W(8), .SEED(8'hA5), .BLINK_W(4)
`ifdef SRAM_BIST_TIMEOUT_EN
    , .TMO_W(4)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ready(ready), .start(start),
    .re(re), .address(address), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_addr(err_addr), .led(led)
`ifdef SRAM_BIST_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  sram_bist #(.ADDR_W(AW2), .DATA_W(8), .SEED(8'hA5), .BLINK_W(4)
`ifdef SRAM_BIST_TIMEOUT_EN
    , .TMO_W(4)
`endif
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .run(run2), .ready(ready2), .start(start2),
    .re(re2), .address(address2), .data_in(data_in2), .data_out(zero_data),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .err_addr(err_addr2), .led(led2)
`ifdef SRAM_BIST_TIMEOUT_EN
    , .timeout(timeout2)
`endif
  );

  // ---------------- driver model (fault injection on the read path) --------
  logic [7:0]    mem [0:N-1];
  int            lat = 3;
  int            cnt;
  logic          pend_rd;
  logic [AW-1:0] pend_a;
  int            fault_mode = 0;  // 0 none, 1 single stuck bit, 2 all lines stuck-0
  int            f_addr = 0, f_bit = 0;
  logic          f_val = 1'b0;
  logic          never_ready = 1'b0;

  function automatic logic [7:0] rd_fault(int a, logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (fault_mode == 1 && a == f_addr) r[f_bit] = f_val;
    if (fault_mode == 2) r = 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] pat(int a, int ph);
    logic [7:0] v;
    v = a[7:0];
    return (v ^ 8'hA5) ^ ((ph != 0) ? 8'hFF : 8'h00);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b1; cnt <= 0; data_out <= 8'h00;
    end else if (cnt != 0) begin
      if (cnt == 1 && !never_ready) begin
        ready <= 1'b1;
        if (pend_rd) data_out <= rd_fault(int'(pend_a), mem[pend_a]);
      end
      if (!(cnt == 1 && never_ready)) cnt <= cnt - 1;
    end else if (start && ready) begin
      ready <= 1'b0; cnt <= lat; pend_rd <= re; pend_a <= address;
      if (!re) mem[address] <= data_in;
    end
  end

  int cnt2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready2 <= 1'b1; cnt2 <= 0;
    end else if (cnt2 != 0) begin
      if (cnt2 == 1) ready2 <= 1'b1;
      cnt2 <= cnt2 - 1;
    end else if (start2 && ready2) begin
      ready2 <= 1'b0; cnt2 <= 3;
    end
  end

  // ---------------- access monitor -----------------------------------------
  typedef struct packed { logic r; logic [AW-1:0] a; logic [7:0] d; } acc_t;
  acc_t       exp_q[$];
  logic [7:0] a3_q[$];
  int starts = 0, seq_err = 0, viol = 0, viol2 = 0;

  initial begin
    acc_t acc;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (start2 && !ready2) viol2++;
        if (start) begin
          starts++;
          if (!ready) viol++;
          if (!re && address == 4'd3) a3_q.push_back(data_in);
          if (exp_q.size() == 0) seq_err++;
          else begin
            acc = exp_q.pop_front();
            if (acc.r !== re || acc.a !== address || (!re && acc.d !== data_in)) seq_err++;
          end
        end
      end
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic build_seq();
    exp_q.delete(); a3_q.delete();
    starts = 0; seq_err = 0; viol = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < N; a++) exp_q.push_back({1'b0, AW'(a), pat(a, ph)});
      for (int a = 0; a < N; a++) exp_q.push_back({1'b1, AW'(a), 8'h00});
    end
  endtask

  task automatic ref_result(input int n, output int ec, output int ea);
    ec = 0; ea = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < n; a++)
        if (rd_fault(a, pat(a, ph)) !== pat(a, ph)) begin
          if (ec == 0) ea = a;
          if (ec < 255) ec++;
        end
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin @(negedge clk); i++; end
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, budget);
    end
  endtask

  task automatic check_result(input string nm, input int ec, input int ea, input logic ps);
    tests++;
    if (err_count !== 8'(ec) || err_addr !== AW'(ea) || pass !== ps || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: err_count=%0d err_addr=%0d pass=%b busy=%b, required %0d %0d %b 0",
               nm, err_count, err_addr, pass, busy, ec, ea, ps);
    end
    tests++;
    if (seq_err !== 0 || viol !== 0 || starts !== 4 * N) begin
      fails++;
      $display("FAIL %s_seq: seq_err=%0d viol=%0d starts=%0d, required 0 0 %0d",
               nm, seq_err, viol, starts, 4 * N);
    end
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({start, re, address, data_in, busy, done, pass, err_count, err_addr, led} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: start=%b re=%b addr=%0d din=%h busy=%b done=%b pass=%b ec=%0d ea=%0d led=%b, required all 0",
               start, re, address, data_in, busy, done, pass, err_count, err_addr, led);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_clean();
    int ec, ea;
    fault_mode = 0; build_seq(); ref_result(N, ec, ea);
    pulse_run(); wait_done(3000);
    check_result("clean", ec, ea, 1'b1);
    tests++;
    if (led !== 1'b1) begin fails++; $display("FAIL clean_led: led=%b, required 1", led); end
    tests++;
    if (a3_q.size() != 2 || a3_q[0] !== 8'hA6 || a3_q[1] !== 8'h59) begin
      fails++;
      $display("FAIL addr3_data: writes=%0d first=%h second=%h, required 2 a6 59",
               a3_q.size(), (a3_q.size() > 0) ? a3_q[0] : 8'hxx, (a3_q.size() > 1) ? a3_q[1] : 8'hxx);
    end
  endtask

  task automatic test_stuck_bit();
    int ec, ea, tog;
    logic prev;
    fault_mode = 1; f_addr = 5; f_bit = 0; f_val = 1'b1;
    build_seq(); ref_result(N, ec, ea);
    pulse_run(); wait_done(3000);
    check_result("stuck_bit", ec, ea, 1'b0);
    prev = led; tog = 0;
    repeat (40) begin @(negedge clk); if (led !== prev) tog++; prev = led; end
    tests++;
    if (tog < 4 || tog > 5) begin fails++; $display("FAIL blink: toggles=%0d in 40 cycles, required 4..5", tog); end
  endtask

  task automatic test_all_zero();
    int ec, ea;
    fault_mode = 2; build_seq(); ref_result(N, ec, ea);
    pulse_run(); wait_done(3000);
    check_result("all_zero", ec, ea, 1'b0);
    tests++;
    if (err_count !== 8'd32) begin fails++; $display("FAIL all_zero_count: err_count=%0d, required 32", err_count); end
  endtask

  task automatic test_saturate();
    int ec, ea, i;
    fault_mode = 2; ref_result(2 ** AW2, ec, ea); viol2 = 0;
    @(negedge clk); run2 = 1'b1; @(negedge clk); run2 = 1'b0;
    i = 0;
    while (!done2 && i < 40000) begin @(negedge clk); i++; end
    tests++;
    if (done2 !== 1'b1 || err_count2 !== 8'(ec) || err_addr2 !== AW2'(ea) || pass2 !== 1'b0 || viol2 !== 0) begin
      fails++;
      $display("FAIL saturate: done=%b err_count=%0d err_addr=%0d pass=%b viol=%0d, required 1 %0d %0d 0 0",
               done2, err_count2, err_addr2, pass2, viol2, ec, ea);
    end
  endtask

  task automatic test_run_while_busy();
    int ec, ea;
    fault_mode = 0; build_seq(); ref_result(N, ec, ea);
    pulse_run();
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(5, 60)) @(negedge clk);
      run = 1'b1; @(negedge clk); run = 1'b0;
    end
    wait_done(3000);
    check_result("run_busy", ec, ea, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    int ec, ea, i;
    fault_mode = 0; build_seq();
    pulse_run();
    i = 0;
    while (!(start && re) && i < 3000) begin @(negedge clk); i++; end
    tests++;
    if (!(start && re)) begin fails++; $display("FAIL rd_start_seen: start=%b re=%b, required 1 1", start, re); end
    reset_n = 1'b0; #1;
    tests++;
    if ({start, busy, done} !== 3'b000) begin
      fails++; $display("FAIL reset_mid_read: start=%b busy=%b done=%b, required 0 0 0", start, busy, done);
    end
    @(negedge clk); reset_n = 1'b1;
    build_seq(); ref_result(N, ec, ea);
    pulse_run(); wait_done(3000);
    check_result("after_reset", ec, ea, 1'b1);
  endtask

  task automatic test_random_faults();
    int ec, ea;
    for (int k = 0; k < 4; k++) begin
      fault_mode = 1;
      f_addr = $urandom_range(0, N - 1); f_bit = $urandom_range(0, 7);
      f_val = 1'($urandom_range(0, 1)); lat = $urandom_range(1, 5);
      build_seq(); ref_result(N, ec, ea);
      pulse_run(); wait_done(4000);
      check_result("random_fault", ec, ea, (ec == 0));
    end
    lat = 3;
  endtask

`ifdef SRAM_BIST_TIMEOUT_EN
  task automatic test_timeout();
    never_ready = 1'b1; build_seq();
    pulse_run(); wait_done(200);
    tests++;
    if (timeout !== 1'b1 || pass !== 1'b0 || err_count !== 8'hFF || err_addr !== '0) begin
      fails++;
      $display("FAIL timeout: timeout=%b pass=%b err_count=%0d err_addr=%0d, required 1 0 255 0",
               timeout, pass, err_count, err_addr);
    end
    never_ready = 1'b0;
    @(negedge clk); reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_stuck_bit();
    test_all_zero();
    test_run_while_busy();
    test_reset_mid_read();
    test_random_faults();
    test_saturate();
`ifdef SRAM_BIST_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
